// File: rtl/mux16_rr_arbiter_pkg.sv
// mux16_rr_arbiter shared definitions:
// requester count, index width, FSM states.
package mux16_rr_arbiter_pkg;

  localparam int ARB_N     = 16;
  localparam int ARB_IDX_W = 4;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// rr_pick16: round-robin winner search over
// 16 requests starting at ptr, optional exclude.
module rr_pick16
  import mux16_rr_arbiter_pkg::*;
(
  input  logic [ARB_N-1:0]     req_i,
  input  logic [ARB_IDX_W-1:0] ptr_i,
  input  logic                 excl_en_i,
  input  logic [ARB_IDX_W-1:0] excl_idx_i,
  output logic                 found_o,
  output logic [ARB_IDX_W-1:0] idx_o
);

  logic [ARB_N-1:0]     mask;
  logic [ARB_N-1:0]     rot;
  logic [2*ARB_N-1:0]   dbl;
  logic [ARB_IDX_W-1:0] off;

  // rotate so ptr lands on bit 0, find first set, rotate back
  always_comb begin
    mask = req_i;
    if (excl_en_i) mask[excl_idx_i] = 1'b0;
    dbl  = {mask, mask} >> ptr_i;
    rot  = dbl[ARB_N-1:0];
    off  = '0;
    for (int i = ARB_N - 1; i >= 0; i--) begin
      if (rot[i]) off = ARB_IDX_W'(i);
    end
    found_o = |rot;
    idx_o   = off + ptr_i;
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin owner of the
// shared mux16x4 read port, with hold-limit preempt.
module mux16_rr_arbiter
  import mux16_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     gnt,
  output logic [ARB_IDX_W-1:0] sel,
  output logic                 valid
);

  localparam bit PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_SAT =
    CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(PREEMPT_EN ? MAX_HOLD - 1 : 0);

  arb_state_e           state_q, state_d;
  logic [ARB_IDX_W-1:0] sel_q, sel_d;
  logic [ARB_IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ARB_N-1:0]     gnt_q, gnt_d;
  logic                 valid_q, valid_d;

  logic                 found;
  logic [ARB_IDX_W-1:0] pick;
  logic                 excl_en;
  logic                 preempt;
  logic                 take;

  // while granted, the current owner is never
  // its own successor
  assign excl_en = (state_q == ARB_GRANT);

  rr_pick16 u_pick (
    .req_i      (req),
    .ptr_i      (ptr_q),
    .excl_en_i  (excl_en),
    .excl_idx_i (sel_q),
    .found_o    (found),
    .idx_o      (pick)
  );

  // >= so an owner that saturated while alone is
  // still handed off once a competitor shows up
  assign preempt = PREEMPT_EN && found &&
                   (cnt_q >= HOLD_LAST);

  // next owner, pointer, hold counter
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    take    = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        take  = found;
      end
      ARB_GRANT: begin
        if (!req[sel_q]) begin
          cnt_d = '0;
          if (found) begin
            take = 1'b1;
          end else begin
            state_d = ARB_IDLE;
            valid_d = 1'b0;
          end
        end else if (preempt) begin
          take = 1'b1;
        end else if (cnt_q != HOLD_SAT) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
    if (take) begin
      state_d = ARB_GRANT;
      sel_d   = pick;
      ptr_d   = pick + 1'b1;
      valid_d = 1'b1;
      cnt_d   = '0;
    end
    gnt_d = valid_d ? (ARB_N'(1) << sel_d) : '0;
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = valid_q;

endmodule
